// File: rtl/arb_pkg.sv
// Shared constants and types for the 4-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned ARB_NUM       = 4;
  localparam int unsigned ARB_KEY_WIDTH = 2;

  typedef logic [ARB_KEY_WIDTH-1:0] arb_key_t;

endpackage

// File: rtl/mux_4_to_1.sv
// Plain 4:1 payload multiplexer selected by a 2-bit key.
module mux_4_to_1 #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [1:0]                 i_key,
  input  logic [3:0][DATA_WIDTH-1:0] i_val,
  output logic [DATA_WIDTH-1:0]      o_val
);

  // Select the keyed word.
  always_comb begin
    o_val = '0;
    unique case (i_key)
      2'd0:    o_val = i_val[0];
      2'd1:    o_val = i_val[1];
      2'd2:    o_val = i_val[2];
      default: o_val = i_val[3];
    endcase
  end

endmodule

// File: rtl/arb_rr_4_to_1.sv
// Round-robin arbiter merging four valid/ready channels into one registered output stage.
module arb_rr_4_to_1
  import arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [ARB_NUM-1:0]         i_valid,
  input  logic [3:0][DATA_WIDTH-1:0] i_data,
  output logic [ARB_NUM-1:0]         o_ready,
  output logic                       o_valid,
  output logic [DATA_WIDTH-1:0]      o_data,
  output logic [ARB_KEY_WIDTH-1:0]   o_key,
  input  logic                       i_ready
);

  // First requester at or after ptr, wrapping modulo 4; returns ptr when nothing requests.
  function automatic arb_key_t rr_pick(input logic [ARB_NUM-1:0] req, input arb_key_t ptr);
    arb_key_t idx;
    rr_pick = ptr;
    // Walk offsets high to low so the nearest requester is the last one written.
    for (int i = ARB_NUM - 1; i >= 0; i--) begin
      idx = ptr + arb_key_t'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  arb_key_t              key_q, key_d;
  arb_key_t              ptr_q, ptr_d;

  logic                  load;
  logic                  any;
  arb_key_t              grant;
  logic [DATA_WIDTH-1:0] mux_val;

  mux_4_to_1 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mux (
    .i_key (grant),
    .i_val (i_data),
    .o_val (mux_val)
  );

  // Arbitration, source handshake and next-state of the output stage.
  always_comb begin
    load    = !valid_q || i_ready;
    any     = |i_valid;
    grant   = rr_pick(i_valid, ptr_q);
    o_ready = '0;
    valid_d = valid_q;
    data_d  = data_q;
    key_d   = key_q;
    ptr_d   = ptr_q;
    if (load && any && !i_rst) o_ready[grant] = 1'b1;
    if (load) begin
      if (any) begin
        valid_d = 1'b1;
        data_d  = mux_val;
        key_d   = grant;
        ptr_d   = grant + arb_key_t'(1);
      end else begin
        // Drained with nothing new: payload and key keep their last values.
        valid_d = 1'b0;
      end
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      key_q   <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      key_q   <= key_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_key   = key_q;

endmodule

// File: tb/tb_arb_rr_4_to_1.sv
// Directed bench for the 4-way round-robin arbiter.
module tb_arb_rr_4_to_1;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [3:0]        i_valid;
  logic [3:0][31:0]  i_data;
  logic [3:0]        o_ready;
  logic              o_valid;
  logic [31:0]       o_data;
  logic [1:0]        o_key;
  logic              i_ready;

  int errors = 0;
  int checks = 0;

  arb_rr_4_to_1 #(
    .DATA_WIDTH (32)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_key   (o_key),
    .i_ready (i_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] d,
                         input logic [1:0] k);
    chk({tag, ".valid"}, 64'(o_valid), 64'(v));
    chk({tag, ".data"},  64'(o_data),  64'(d));
    chk({tag, ".key"},   64'(o_key),   64'(k));
  endtask

  initial begin
    logic [3:0] exp_r;
    logic [1:0] exp_k;

    i_rst   = 1'b1;
    i_valid = 4'b1111;
    i_ready = 1'b1;
    i_data[0] = 32'h1;
    i_data[1] = 32'h2;
    i_data[2] = 32'h3;
    i_data[3] = 32'h4;

    // Reset held two cycles with everyone requesting.
    tick();
    tick();
    chk_out("reset", 1'b0, 32'h0, 2'd0);
    chk("reset.ready", 64'(o_ready), 64'(4'b0000));

    // Round-robin with all requesting from a fresh pointer.
    i_rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_k = 2'(k % 4);
      exp_r = 4'b0001 << exp_k;
      chk("rr.ready", 64'(o_ready), 64'(exp_r));
      tick();
      chk_out("rr", 1'b1, 32'(exp_k) + 32'h1, exp_k);
    end

    // Single source 2.
    i_valid = 4'b0100;
    #1;
    chk("single.ready", 64'(o_ready), 64'(4'b0100));
    tick();
    chk_out("single", 1'b1, 32'h3, 2'd2);

    // Grant 3, then 0110 must go 1 then 2 after the pointer wraps to 0.
    i_valid = 4'b1000;
    tick();
    chk_out("wrap.g3", 1'b1, 32'h4, 2'd3);
    i_valid = 4'b0110;
    #1;
    chk("wrap.ready1", 64'(o_ready), 64'(4'b0010));
    tick();
    chk_out("wrap.g1", 1'b1, 32'h2, 2'd1);
    #1;
    chk("wrap.ready2", 64'(o_ready), 64'(4'b0100));
    tick();
    chk_out("wrap.g2", 1'b1, 32'h3, 2'd2);

    // Backpressure: load source 1, then stall five cycles with all requesting.
    i_valid = 4'b0010;
    tick();
    chk_out("bp.load", 1'b1, 32'h2, 2'd1);
    i_ready = 1'b0;
    i_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp.ready", 64'(o_ready), 64'(4'b0000));
      tick();
      chk_out("bp.hold", 1'b1, 32'h2, 2'd1);
    end
    i_ready = 1'b1;
    #1;
    chk("bp.release.ready", 64'(o_ready), 64'(4'b0100));
    tick();
    chk_out("bp.release", 1'b1, 32'h3, 2'd2);

    // Drain with no request: valid drops, payload/key hold, pointer unchanged.
    i_valid = 4'b0000;
    #1;
    chk("drain.ready", 64'(o_ready), 64'(4'b0000));
    tick();
    chk_out("drain", 1'b0, 32'h3, 2'd2);
    i_valid = 4'b1111;
    #1;
    chk("drain.ptr", 64'(o_ready), 64'(4'b1000));
    tick();
    chk_out("drain.next", 1'b1, 32'h4, 2'd3);

    // Reset during a stall.
    i_ready = 1'b0;
    tick();
    chk_out("rst.stall", 1'b1, 32'h4, 2'd3);
    i_rst = 1'b1;
    #1;
    chk("rst.ready", 64'(o_ready), 64'(4'b0000));
    tick();
    chk_out("rst.mid", 1'b0, 32'h0, 2'd0);
    i_rst   = 1'b0;
    i_ready = 1'b1;
    #1;
    chk("rst.after.ready", 64'(o_ready), 64'(4'b0001));
    tick();
    chk_out("rst.after", 1'b1, 32'h1, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a runaway simulation.
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
